// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
// Multi-cycle control FSM for the RV32I-subset datapath: latches the fetched
// instruction into IR, decodes it, and sequences FETCH/EXEC or FETCH/MEM/WB.
module multicycle_control #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [31:0]  instruction,
    input  logic         zero,
    output logic         branch,
    output logic         is_lui,
    output logic         is_jal,
    output logic         is_jalr,
    output logic         mem2reg,
    output logic         memwrite,
    output logic         alusrc,
    output logic         regwrite,
    output logic [3:0]   aluctl,
    output logic         pcwrite,
    output logic         halted,
    output logic         illegal,
    output logic [W-1:0] retired
);

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [XLEN-1:0]   ir;
    logic [4:0]        ir_r_dec;
    logic [4:0]        ir_i_dec;
    logic              fetch_legal;
    logic              unused_bits;

    // R-type funct7/funct3 to {supported, aluctl}
    function automatic logic [4:0] dec_r(input logic [6:0] f7, input logic [2:0] f3);
        dec_r = {1'b0, ALU_AND};
        case ({f7, f3})
            {7'b0000000, 3'b000}: dec_r = {1'b1, ALU_ADD};
            {7'b0100000, 3'b000}: dec_r = {1'b1, ALU_SUB};
            {7'b0000000, 3'b111}: dec_r = {1'b1, ALU_AND};
            {7'b0000000, 3'b110}: dec_r = {1'b1, ALU_OR};
            {7'b0000000, 3'b010}: dec_r = {1'b1, ALU_SLT};
            default:              dec_r = {1'b0, ALU_AND};
        endcase
    endfunction

    // I-ALU funct3 to {supported, aluctl}
    function automatic logic [4:0] dec_i(input logic [2:0] f3);
        dec_i = {1'b0, ALU_AND};
        case (f3)
            3'b000:  dec_i = {1'b1, ALU_ADD};
            3'b111:  dec_i = {1'b1, ALU_AND};
            3'b110:  dec_i = {1'b1, ALU_OR};
            3'b010:  dec_i = {1'b1, ALU_SLT};
            default: dec_i = {1'b0, ALU_AND};
        endcase
    endfunction

    // Whether an encoding is supported (SYSTEM counts as supported; it halts cleanly)
    function automatic logic is_legal(input logic [31:0] i);
        logic [4:0] r_d;
        logic [4:0] i_d;
        r_d = dec_r(i[31:25], i[14:12]);
        i_d = dec_i(i[14:12]);
        case (i[6:0])
            OP_R:                   is_legal = r_d[4];
            OP_I:                   is_legal = i_d[4];
            OP_LUI, OP_JAL, OP_SYS: is_legal = 1'b1;
            OP_BR, OP_JALR:         is_legal = (i[14:12] == 3'b000);
            OP_ST, OP_LD:           is_legal = (i[14:12] == 3'b010);
            default:                is_legal = 1'b0;
        endcase
    endfunction

    assign ir_r_dec    = dec_r(ir[31:25], ir[14:12]);
    assign ir_i_dec    = dec_i(ir[14:12]);
    assign fetch_legal = is_legal(instruction);

    // Register fields and the zero flag are not needed by the controller
    assign unused_bits = ^{zero, ir[24:15], ir[11:7], ir_r_dec[4], ir_i_dec[4]};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; FETCH routes on the incoming instruction as IR loads
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (run) next_state = S_FETCH;
            end
            S_FETCH: begin
                if (!run)                          next_state = S_IDLE;
                else if (!fetch_legal)             next_state = S_HALT;
                else if (instruction[6:0] == OP_SYS) next_state = S_HALT;
                else if (instruction[6:0] == OP_LD)  next_state = S_MEM;
                else                               next_state = S_EXEC;
            end
            S_EXEC:  next_state = S_FETCH;
            S_MEM:   next_state = S_WB;
            S_WB:    next_state = S_FETCH;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    // Control outputs decoded from state and IR only
    always_comb begin
        branch   = 1'b0;
        is_lui   = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        mem2reg  = 1'b0;
        memwrite = 1'b0;
        alusrc   = 1'b0;
        regwrite = 1'b0;
        aluctl   = ALU_AND;
        pcwrite  = 1'b0;
        halted   = 1'b0;
        case (state)
            S_EXEC: begin
                case (ir[6:0])
                    OP_R: begin
                        regwrite = 1'b1;
                        pcwrite  = 1'b1;
                        aluctl   = ir_r_dec[3:0];
                    end
                    OP_I: begin
                        regwrite = 1'b1;
                        alusrc   = 1'b1;
                        pcwrite  = 1'b1;
                        aluctl   = ir_i_dec[3:0];
                    end
                    OP_LUI: begin
                        is_lui   = 1'b1;
                        regwrite = 1'b1;
                        pcwrite  = 1'b1;
                    end
                    OP_BR: begin
                        branch  = 1'b1;
                        aluctl  = ALU_SUB;
                        pcwrite = 1'b1;
                    end
                    OP_JAL: begin
                        is_jal   = 1'b1;
                        regwrite = 1'b1;
                        pcwrite  = 1'b1;
                    end
                    OP_JALR: begin
                        is_jalr  = 1'b1;
                        regwrite = 1'b1;
                        pcwrite  = 1'b1;
                    end
                    OP_ST: begin
                        memwrite = 1'b1;
                        alusrc   = 1'b1;
                        aluctl   = ALU_ADD;
                        pcwrite  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem2reg = 1'b1;
                alusrc  = 1'b1;
                aluctl  = ALU_ADD;
            end
            S_WB: begin
                mem2reg  = 1'b1;
                alusrc   = 1'b1;
                aluctl   = ALU_ADD;
                regwrite = 1'b1;
                pcwrite  = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // IR load and sticky illegal flag, both captured in FETCH while run is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir      <= '0;
            illegal <= 1'b0;
        end else if (state == S_FETCH && run) begin
            ir <= instruction;
            if (!fetch_legal) illegal <= 1'b1;
        end
    end

    // Retired-instruction counter: one count per PC update, wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (pcwrite) begin
            retired <= retired + W'(1);
        end
    end

endmodule
